// File: rtl/alu_nibble_sequencer_if.sv
// Request/result handshake bundle between a requester and alu_nibble_sequencer.
// The master drives operands and result acceptance; the slave (sequencer) answers.
interface alu_nibble_sequencer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [3:0]       op_s;
  logic             op_m;
  logic             op_cn;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_f;
  logic             res_cout;
  logic             res_equal;

  modport master (
    output req_valid, op_a, op_b, op_s, op_m, op_cn, res_ready,
    input  req_ready, res_valid, res_f, res_cout, res_equal
  );

  modport slave (
    input  req_valid, op_a, op_b, op_s, op_m, op_cn, res_ready,
    output req_ready, res_valid, res_f, res_cout, res_equal
  );
endinterface

// File: rtl/alu_nibble_sequencer.sv
// Runs one WIDTH-bit 74181 operation as WIDTH/4 nibble steps through a single shared slice,
// LSB nibble first, feeding each step's cn4 back as the next step's cn.
module alu_nibble_sequencer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ena_i,
  alu_nibble_sequencer_if.slave        bus_io,
  output logic [3:0]                   alu_a_o,
  output logic [3:0]                   alu_b_o,
  output logic [3:0]                   alu_s_o,
  output logic                         alu_m_o,
  output logic                         alu_cn_o,
  input  logic [3:0]                   alu_f_i,
  input  logic                         alu_cn4_i,
  input  logic                         alu_equal_i,
  output logic                         busy_o
);

  localparam int unsigned Nibbles = WIDTH / 4;
  localparam int unsigned CntW    = (Nibbles > 1) ? $clog2(Nibbles) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Nibbles - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;
  logic             eq_q, eq_d;
  logic             accept;

  assign bus_io.req_ready = ena_i && (state_q == StIdle);
  assign bus_io.res_valid = (state_q == StDone);
  assign accept           = bus_io.req_ready && bus_io.req_valid;

  // Slice inputs always mirror the registers so they are defined in every state.
  assign alu_a_o  = a_q[3:0];
  assign alu_b_o  = b_q[3:0];
  assign alu_s_o  = s_q;
  assign alu_m_o  = m_q;
  assign alu_cn_o = carry_q;

  assign bus_io.res_f     = res_q;
  assign bus_io.res_cout  = carry_q;
  assign bus_io.res_equal = eq_q;
  assign busy_o           = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    s_d     = s_q;
    m_d     = m_q;
    carry_d = carry_q;
    eq_d    = eq_q;

    if (ena_i) begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            a_d     = bus_io.op_a;
            b_d     = bus_io.op_b;
            s_d     = bus_io.op_s;
            m_d     = bus_io.op_m;
            carry_d = bus_io.op_cn;
            eq_d    = 1'b1;
            cnt_d   = '0;
            state_d = StRun;
          end
        end
        StRun: begin
          res_d   = {alu_f_i, res_q[WIDTH-1:4]};
          carry_d = alu_cn4_i;
          eq_d    = eq_q & alu_equal_i;
          a_d     = {4'b0000, a_q[WIDTH-1:4]};
          b_d     = {4'b0000, b_q[WIDTH-1:4]};
          cnt_d   = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end
        end
        StDone: begin
          if (bus_io.res_ready) begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      s_q     <= s_d;
      m_q     <= m_d;
      carry_q <= carry_d;
      eq_q    <= eq_d;
    end
  end

endmodule
